// File: rtl/ptb_pkg.sv
// Shared encodings and reset constants for the pedestal trigger bank.
package ptb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REARM = 2'd2
    } ptb_state_e;

    localparam logic [1:0] OSEL_DIFF = 2'd0;
    localparam logic [1:0] OSEL_BASE = 2'd1;
    localparam logic [1:0] OSEL_RAW  = 2'd2;
    localparam logic [1:0] OSEL_ZERO = 2'd3;

    localparam logic [1:0] CFG_THR     = 2'd0;
    localparam logic [1:0] CFG_HOLDOFF = 2'd1;
    localparam logic [1:0] CFG_COUNT   = 2'd2;
    localparam logic [1:0] CFG_BASE    = 2'd3;

    localparam int RST_HOLDOFF = 16;

endpackage

// File: rtl/pedestal_trigger_bank_if.sv
// Configuration bus of the pedestal trigger bank (write strobe, select,
// channel address, write data and registered read data).
interface pedestal_trigger_bank_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    import ptb_pkg::*;

    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic [DW-1:0] cfg_rdata;

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        output cfg_rdata
    );

endinterface

// File: rtl/ptb_channel.sv
// One channel: tracking pedestal, saturated difference, trigger FSM and,
// with PTB_TRIG_COUNT_EN defined, a saturating trigger counter.
module ptb_channel
    import ptb_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AVG_SHIFT = 6,
    parameter int HOW       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           output_selector,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] threshold,
    input  logic [HOW-1:0]       holdoff,
    input  logic                 cnt_clr,
    output logic signed [DW-1:0] y,
    output logic                 trigger,
    output logic [DW-1:0]        baseline,
    output logic [DW-1:0]        count
);
    localparam int AW = DW + AVG_SHIFT;

    ptb_state_e state_q, state_d;
    logic [HOW-1:0] hcnt_q, hcnt_d;
    logic signed [AW-1:0] acc_q;
    logic init_q;
    logic signed [DW-1:0] base_eff;
    logic signed [DW-1:0] diff;
    logic signed [DW:0] dfull;
    logic fire;
    logic acc_upd;

    assign baseline = acc_q[AW-1:AVG_SHIFT];
    // Before the first sample the pedestal is the sample itself.
    assign base_eff = init_q ? $signed(baseline) : x;
    assign dfull = {x[DW-1], x} - {base_eff[DW-1], base_eff};

    always_comb begin
        diff = dfull[DW-1:0];
        if (dfull[DW] != dfull[DW-1])
            diff = {dfull[DW], {(DW-1){~dfull[DW]}}};
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        fire    = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (diff > threshold) begin
                        state_d = ST_HOLD;
                        hcnt_d  = HOW'(1);
                        fire    = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hcnt_q >= holdoff)
                        state_d = ST_REARM;
                    else
                        hcnt_d = hcnt_q + 1'b1;
                end
                ST_REARM: begin
                    if (diff <= threshold)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The sample that fires is kept out of the pedestal.
    assign acc_upd = enable && (state_q == ST_IDLE)
                     && (!init_q || !fire);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            acc_q   <= '0;
            init_q  <= 1'b0;
            trigger <= 1'b0;
            y       <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            trigger <= fire;
            if (acc_upd) begin
                init_q <= 1'b1;
                if (init_q)
                    acc_q <= acc_q
                           + {{(AVG_SHIFT-1){dfull[DW]}}, dfull};
                else
                    acc_q <= {x, {AVG_SHIFT{1'b0}}};
            end
            unique case (output_selector)
                OSEL_DIFF: y <= diff;
                OSEL_BASE: y <= base_eff;
                OSEL_RAW:  y <= x;
                OSEL_ZERO: y <= '0;
            endcase
        end
    end

`ifdef PTB_TRIG_COUNT_EN
    logic [DW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || cnt_clr)
            cnt_q <= '0;
        else if (fire && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end

    assign count = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign count = '0;
`endif

endmodule

// File: rtl/pedestal_trigger_bank.sv
// NCH-channel pedestal tracker and trigger with config decode/readback.
// PTB_TRIG_COUNT_EN builds the per-channel trigger counters.
module pedestal_trigger_bank
    import ptb_pkg::*;
#(
    parameter int NCH       = 40,
    parameter int DW        = 16,
    parameter int AVG_SHIFT = 6,
    parameter int HOW       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NCH*DW-1:0] x,
    input  logic [1:0]        output_selector,
    pedestal_trigger_bank_if.slave cfg,
    output logic [NCH*DW-1:0] y,
    output logic [NCH-1:0]    trigger
);
    localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DW-1:0] THR_RST = {1'b0, {(DW-1){1'b1}}};

    logic signed [DW-1:0] thr_q [NCH];
    logic [HOW-1:0] hold_q [NCH];
    logic [DW-1:0] base_w [NCH];
    logic [DW-1:0] cnt_w [NCH];
    logic [NCH-1:0] clr;
    logic addr_ok;
    logic [DW-1:0] rd_d;

    assign addr_ok = int'(cfg.cfg_addr) < NCH;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NCH; n++) begin
                thr_q[n]  <= THR_RST;
                hold_q[n] <= HOW'(RST_HOLDOFF);
            end
        end else if (cfg.cfg_we && addr_ok) begin
            unique case (cfg.cfg_sel)
                CFG_THR:
                    thr_q[cfg.cfg_addr] <= cfg.cfg_wdata;
                CFG_HOLDOFF:
                    hold_q[cfg.cfg_addr] <= cfg.cfg_wdata[HOW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_d = '0;
        if (addr_ok) begin
            unique case (cfg.cfg_sel)
                CFG_THR:     rd_d = thr_q[cfg.cfg_addr];
                CFG_HOLDOFF: rd_d = DW'(hold_q[cfg.cfg_addr]);
                CFG_COUNT:   rd_d = cnt_w[cfg.cfg_addr];
                CFG_BASE:    rd_d = base_w[cfg.cfg_addr];
            endcase
        end
    end

    // Read data only moves on non-write cycles.
    always_ff @(posedge clk) begin
        if (reset)
            cfg.cfg_rdata <= '0;
        else if (!cfg.cfg_we)
            cfg.cfg_rdata <= rd_d;
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        assign clr[n] = cfg.cfg_we && addr_ok
                        && (cfg.cfg_sel == CFG_COUNT)
                        && (cfg.cfg_addr == AW'(n));

        ptb_channel #(
            .DW(DW),
            .AVG_SHIFT(AVG_SHIFT),
            .HOW(HOW)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .enable(enable),
            .output_selector(output_selector),
            .x(x[n*DW +: DW]),
            .threshold(thr_q[n]),
            .holdoff(hold_q[n]),
            .cnt_clr(clr[n]),
            .y(y[n*DW +: DW]),
            .trigger(trigger[n]),
            .baseline(base_w[n]),
            .count(cnt_w[n])
        );
    end

endmodule
